registro_enable_vga: RTL and testbench
======================================

Name: registro_enable_vga

Overview:
- Receiving end of the PicoBlaze one-hot register-enable bus that feeds the VGA path.
- Encodes the 9-bit one-hot enable back to a register index and captures PicoBlaze output data into a shadow bank.
- Once all registers have been written, commits the shadow bank to the display bank on the next frame boundary, so the VGA never sees a half-updated frame.
- Provides registered read-back of the shadow bank to the PicoBlaze input port.

Parameters:
- N_REG, 9, number of registers; equals enable width.
- ANCHO, 8, data width per register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- enable  input  N_REG  one-hot register enable from the address decoder.
- write_strobe  input  1  PicoBlaze write strobe, aligned with enable and dato_in.
- dato_in  input  ANCHO  PicoBlaze out_port data.
- vsync_tick  input  1  one-cycle pulse at the VGA frame boundary.
- clr_error  input  1  clears error_enable.
- read_addr  input  4  shadow register index for read-back.
- dato_out  output  ANCHO  registered read-back data.
- regs_vga  output  N_REG*ANCHO  display bank; register i occupies bits [ANCHO*i+ANCHO-1 : ANCHO*i].
- indice  output  4  binary index of the last accepted write.
- listo  output  1  high while all N_REG shadow registers are written and awaiting commit.
- actualizado  output  1  one-cycle pulse on the cycle after a commit.
- error_enable  output  1  sticky flag: write attempted with a non-one-hot enable.

Behaviour:
- Reset, synchronous, active-high, on clk rising edge, overrides everything:
  - shadow bank, display bank, written-mask, dato_out and indice all go to 0.
  - listo, actualizado and error_enable go to 0.
  - FSM goes to CARGA.
- Encoding (combinational):
  - onehot_ok is true when exactly one bit of enable is set; idx is that bit position (0..8).
  - enable = 0 is a no-op and not an error.
- Accepted write: write_strobe=1 and onehot_ok. At the next edge:
  - shadow[idx] <= dato_in.
  - mask[idx] <= 1.
  - indice <= idx.
  - Rewriting an already-written index overwrites the data; the mask is unchanged.
- Bad write: write_strobe=1 with two or more enable bits set.
  - No register or mask change.
  - error_enable <= 1 at the next edge and holds until reset or clr_error.
  - If clr_error and a bad write occur in the same cycle, the set wins.
- write_strobe=0: enable is ignored entirely.
- FSM:
  - CARGA: listo=0. Moves to LISTO on the edge where the mask becomes all ones, including when the completing write happens in that cycle.
  - LISTO: listo=1. Writes are still accepted into the shadow bank. On vsync_tick=1, goes to COMMIT.
  - COMMIT: lasts one cycle. Copies all shadow registers to regs_vga, clears the mask, then returns to CARGA.
  - vsync_tick in CARGA is ignored; regs_vga holds its value.
- Commit timing:
  - regs_vga updates at the edge leaving COMMIT.
  - actualizado is high for exactly the following cycle.
  - Latency from the vsync_tick edge to regs_vga valid is 2 cycles.
- Write during the COMMIT cycle:
  - Shadow is updated and the mask bit for the new write stays set for the next frame.
  - The copy uses shadow contents from before this write.
- Read-back:
  - dato_out <= shadow[read_addr], 1-cycle latency.
  - read_addr > N_REG-1 returns 0.
  - Read and write to the same index in one cycle return the old value.
- Reset mid-frame (any state): partial shadow writes are discarded and regs_vga is cleared to 0.

Test Plan:
- Reset, then write 0x10+i to each enable bit 0..8 in order (strobe high) -> listo=1 one cycle after the 9th write; regs_vga still all 0.
- From listo=1, pulse vsync_tick -> 2 cycles later regs_vga[7:0]=0x10 and regs_vga[71:64]=0x18; actualizado is high exactly one cycle; listo=0; FSM in CARGA.
- Write enable=9'b000000011, dato 0xAA -> no shadow change, error_enable=1. Then pulse clr_error -> error_enable=0.
- Write only registers 0..7, then pulse vsync_tick -> no commit; regs_vga unchanged; listo=0. Then write register 8 = 0x55 -> listo=1, indice=8.
- read_addr=3 after writing 0x3C to register 3 -> dato_out=0x3C one cycle later. read_addr=12 -> dato_out=0x00.
- In LISTO, assert vsync_tick, then in the COMMIT cycle write register 2 = 0x77 -> regs_vga byte 2 holds the old value; mask=9'b000000100 afterwards; a later read of index 2 returns 0x77.

Source files
------------

// File: rtl/registro_enable_vga_if.sv
`default_nettype none
// ============================================================================
// registro_enable_vga_if
// PicoBlaze-side bus of the VGA register bank: one-hot enable, write data and
// shadow read-back.
// Rev 1.0 - initial release
// ============================================================================
interface registro_enable_vga_if #(
  parameter int N_REG = 9,
  parameter int ANCHO = 8
);
  logic [N_REG-1:0] enable;
  logic             write_strobe;
  logic [ANCHO-1:0] dato_in;
  logic [3:0]       read_addr;
  logic [ANCHO-1:0] dato_out;

  modport master (
    output enable,
    output write_strobe,
    output dato_in,
    output read_addr,
    input  dato_out
  );

  modport slave (
    input  enable,
    input  write_strobe,
    input  dato_in,
    input  read_addr,
    output dato_out
  );
endinterface
`default_nettype wire

// File: rtl/registro_enable_vga.sv
`default_nettype none
// ============================================================================
// registro_enable_vga
// Shadow/display register bank fed by a one-hot enable bus; commits a full
// shadow bank to the display bank on a frame boundary.
// Rev 1.0 - initial release
// ============================================================================
module registro_enable_vga #(
  parameter int N_REG = 9,
  parameter int ANCHO = 8
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  registro_enable_vga_if.slave        bus,
  input  wire logic                   vsync_tick,
  input  wire logic                   clr_error,
  output logic [N_REG*ANCHO-1:0]      regs_vga,
  output logic [3:0]                  indice,
  output logic                        listo,
  output logic                        actualizado,
  output logic                        error_enable
);

  typedef enum logic [1:0] {
    CARGA  = 2'd0,
    LISTO  = 2'd1,
    COMMIT = 2'd2
  } estado_t;

  localparam logic [3:0]       c_max_addr = 4'(N_REG - 1);
  localparam logic [N_REG-1:0] c_uno      = {{(N_REG-1){1'b0}}, 1'b1};

  estado_t                r_estado;
  logic [ANCHO-1:0]       r_shadow [N_REG];
  logic [N_REG-1:0]       r_mask;
  logic [N_REG*ANCHO-1:0] r_regs_vga;
  logic [ANCHO-1:0]       r_dato_out;
  logic [3:0]             r_indice;
  logic                   r_listo;
  logic                   r_actualizado;
  logic                   r_error;

  logic [3:0]       w_idx;
  logic             w_onehot_ok;
  logic             w_multi;
  logic             w_acepta;
  logic             w_malo;
  logic [N_REG-1:0] w_sel;
  logic [N_REG-1:0] w_mask_base;
  logic [N_REG-1:0] w_mask_next;

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < N_REG; i++) begin
      if (bus.enable[i]) w_idx = 4'(i);
    end
  end

  // Power-of-two test: clearing the lowest set bit leaves nothing.
  assign w_onehot_ok = (bus.enable != '0) && ((bus.enable & (bus.enable - c_uno)) == '0);
  assign w_multi     = (bus.enable != '0) && !w_onehot_ok;
  assign w_acepta    = bus.write_strobe && w_onehot_ok;
  assign w_malo      = bus.write_strobe && w_multi;
  assign w_sel       = w_acepta ? bus.enable : '0;

  // The commit cycle starts a fresh frame, so a write landing there survives.
  assign w_mask_base = (r_estado == COMMIT) ? '0 : r_mask;
  assign w_mask_next = w_mask_base | w_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado      <= CARGA;
      for (int i = 0; i < N_REG; i++) r_shadow[i] <= '0;
      r_mask        <= '0;
      r_regs_vga    <= '0;
      r_dato_out    <= '0;
      r_indice      <= 4'd0;
      r_listo       <= 1'b0;
      r_actualizado <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_acepta) begin
        r_shadow[w_idx] <= bus.dato_in;
        r_indice        <= w_idx;
      end
      r_mask <= w_mask_next;

      if (w_malo)         r_error <= 1'b1;
      else if (clr_error) r_error <= 1'b0;

      if (bus.read_addr <= c_max_addr) r_dato_out <= r_shadow[bus.read_addr];
      else                             r_dato_out <= '0;

      r_actualizado <= (r_estado == COMMIT);

      case (r_estado)
        CARGA: begin
          if (&w_mask_next) begin
            r_estado <= LISTO;
            r_listo  <= 1'b1;
          end
        end
        LISTO: begin
          if (vsync_tick) begin
            r_estado <= COMMIT;
            r_listo  <= 1'b0;
          end
        end
        COMMIT: begin
          // Copy sees the shadow as it was before any write in this cycle.
          for (int i = 0; i < N_REG; i++) r_regs_vga[i*ANCHO +: ANCHO] <= r_shadow[i];
          r_estado <= CARGA;
        end
        default: begin
          r_estado <= CARGA;
          r_listo  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dato_out  = r_dato_out;
  assign regs_vga      = r_regs_vga;
  assign indice        = r_indice;
  assign listo         = r_listo;
  assign actualizado   = r_actualizado;
  assign error_enable  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_registro_enable_vga.sv
`default_nettype none
// ============================================================================
// tb_registro_enable_vga
// Vector table, directed corner sequences and random traffic against a model.
// Rev 1.0 - initial release
// ============================================================================
module tb_registro_enable_vga;

  localparam int NR = 9;
  localparam int AN = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync_tick;
  logic          clr_error;
  logic [NR*AN-1:0] regs_vga;
  logic [3:0]    indice;
  logic          listo;
  logic          actualizado;
  logic          error_enable;

  registro_enable_vga_if #(.N_REG(NR), .ANCHO(AN)) bus ();

  registro_enable_vga #(.N_REG(NR), .ANCHO(AN)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .vsync_tick   (vsync_tick),
    .clr_error    (clr_error),
    .regs_vga     (regs_vga),
    .indice       (indice),
    .listo        (listo),
    .actualizado  (actualizado),
    .error_enable (error_enable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, written set, frame-ready/commit flags.
  logic [7:0] m_shadow [NR];
  logic [7:0] m_disp   [NR];
  bit         m_written[NR];
  bit         m_ready, m_commit, m_act, m_err;
  logic [3:0] m_ind;
  logic [7:0] m_dout;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] disp_vec();
    logic [71:0] v;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = m_disp[i];
    return v;
  endfunction

  task automatic model_step();
    int n, k;
    bit all_w, nxt_commit;
    logic [7:0] old [NR];
    n = 0; k = 0;
    for (int i = 0; i < NR; i++) if (bus.enable[i]) begin n++; k = i; end
    old = m_shadow;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_shadow[i] = 8'h00; m_disp[i] = 8'h00; m_written[i] = 1'b0;
      end
      m_ready = 0; m_commit = 0; m_act = 0; m_err = 0; m_ind = 4'd0; m_dout = 8'h00;
    end else begin
      if (int'(bus.read_addr) < NR) m_dout = old[bus.read_addr];
      else                          m_dout = 8'h00;
      m_act = m_commit;
      if (m_commit) begin
        m_disp = old;
        for (int i = 0; i < NR; i++) m_written[i] = 1'b0;
      end
      if (bus.write_strobe && n == 1) begin
        m_shadow[k] = bus.dato_in; m_written[k] = 1'b1; m_ind = k[3:0];
      end
      if (bus.write_strobe && n > 1) m_err = 1'b1;
      else if (clr_error)            m_err = 1'b0;
      all_w = 1'b1;
      for (int i = 0; i < NR; i++) if (!m_written[i]) all_w = 1'b0;
      nxt_commit = m_ready && vsync_tick;
      if (m_commit)     m_ready = 1'b0;
      else if (m_ready) m_ready = !vsync_tick;
      else              m_ready = all_w;
      m_commit = nxt_commit;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("dato_out",     {64'd0, bus.dato_out}, {64'd0, m_dout});
    check("regs_vga",     regs_vga, disp_vec());
    check("indice",       {68'd0, indice}, {68'd0, m_ind});
    check("listo",        {71'd0, listo}, {71'd0, m_ready});
    check("actualizado",  {71'd0, actualizado}, {71'd0, m_act});
    check("error_enable", {71'd0, error_enable}, {71'd0, m_err});
  endtask

  task automatic drive(input logic [8:0] en, input logic ws, input logic [7:0] din,
                       input logic vs, input logic clr, input logic [3:0] ra);
    bus.enable = en; bus.write_strobe = ws; bus.dato_in = din;
    vsync_tick = vs; clr_error = clr; bus.read_addr = ra;
  endtask

  task automatic write_reg(input int idx, input logic [7:0] d, input logic [3:0] ra);
    logic [8:0] e;
    e = '0; e[idx] = 1'b1;
    drive(e, 1'b1, d, 1'b0, 1'b0, ra);
    tick();
  endtask

  typedef struct {
    logic [8:0] en; logic ws; logic [7:0] din; logic vs; logic clr; logic [3:0] ra;
    logic [3:0] e_ind; logic e_listo; logic e_act; logic e_err; logic [7:0] e_dout;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 9; i++) begin
      logic [8:0] e;
      e = '0; e[i] = 1'b1;
      tbl[i] = '{e, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 4'(i), 4'(i), (i == 8), 1'b0, 1'b0, 8'h00};
    end
    tbl[9]  = '{9'h000, 1'b0, 8'h00, 1'b1, 1'b0, 4'd3,  4'd8, 1'b0, 1'b0, 1'b0, 8'h13};
    tbl[10] = '{9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd12, 4'd8, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{9'h003, 1'b1, 8'hAA, 1'b0, 1'b0, 4'd0,  4'd8, 1'b0, 1'b0, 1'b1, 8'h10};
    tbl[12] = '{9'h000, 1'b0, 8'h00, 1'b0, 1'b1, 4'd1,  4'd8, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[13] = '{9'h000, 1'b1, 8'h99, 1'b0, 1'b0, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0, 8'h18};

    reset = 1'b1;
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    check("rst_regs_vga", regs_vga, 72'd0);
    check("rst_listo", {71'd0, listo}, 72'd0);
    check("rst_dato_out", {64'd0, bus.dato_out}, 72'd0);
    reset = 1'b0;

    // Load all nine, commit, bad enable, clear
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].ws, tbl[i].din, tbl[i].vs, tbl[i].clr, tbl[i].ra);
      tick();
      check("tbl_indice", {68'd0, indice}, {68'd0, tbl[i].e_ind});
      check("tbl_listo", {71'd0, listo}, {71'd0, tbl[i].e_listo});
      check("tbl_actualizado", {71'd0, actualizado}, {71'd0, tbl[i].e_act});
      check("tbl_error", {71'd0, error_enable}, {71'd0, tbl[i].e_err});
      check("tbl_dato_out", {64'd0, bus.dato_out}, {64'd0, tbl[i].e_dout});
    end
    check("commit_byte0", {64'd0, regs_vga[7:0]},   72'h10);
    check("commit_byte8", {64'd0, regs_vga[71:64]}, 72'h18);
    check("commit_byte2", {64'd0, regs_vga[23:16]}, 72'h12);

    // Incomplete frame ignores vsync
    for (int i = 0; i < 8; i++) write_reg(i, 8'(8'h20 + i), 4'd0);
    drive(9'h000, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    tick();
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    check("no_commit_listo", {71'd0, listo}, 72'd0);
    check("no_commit_byte2", {64'd0, regs_vga[23:16]}, 72'h12);
    write_reg(8, 8'h55, 4'd0);
    check("complete_listo", {71'd0, listo}, 72'd1);
    check("complete_indice", {68'd0, indice}, 72'd8);

    // Read-back latency and out-of-range address
    write_reg(3, 8'h3C, 4'd0);
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3);
    tick();
    check("read_idx3", {64'd0, bus.dato_out}, 72'h3C);
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd12);
    tick();
    check("read_idx12", {64'd0, bus.dato_out}, 72'h00);

    // Write landing in the commit cycle
    drive(9'h000, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    tick();
    write_reg(2, 8'h77, 4'd0);
    check("cc_byte2_old", {64'd0, regs_vga[23:16]}, 72'h22);
    check("cc_byte3", {64'd0, regs_vga[31:24]}, 72'h3C);
    check("cc_byte8", {64'd0, regs_vga[71:64]}, 72'h55);
    check("cc_actualizado", {71'd0, actualizado}, 72'd1);
    for (int i = 0; i < NR; i++) begin
      if (i != 2) begin
        write_reg(i, 8'(8'h40 + i), 4'd0);
        check("cc_mask_listo", {71'd0, listo}, {71'd0, (i == 8)});
      end
    end
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2);
    tick();
    check("cc_read2", {64'd0, bus.dato_out}, 72'h77);

    // Reset mid-frame clears display bank
    reset = 1'b1;
    drive(9'h000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    reset = 1'b0;
    check("midrst_regs", regs_vga, 72'd0);
    check("midrst_listo", {71'd0, listo}, 72'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [8:0] e;
      r = int'($urandom_range(0, 99));
      if (r < 60)      begin e = '0; e[$urandom_range(0, NR-1)] = 1'b1; end
      else if (r < 75) e = 9'h000;
      else             e = 9'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      drive(e, ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
